cv32e40p_xmem_data_arbiter: RTL
===============================

// Module: cv32e40p_xmem_data_arbiter
// PURPOSE
//  Shares the single OBI data port of the core/coprocessor subsystem between two requesters:
//  the core LSU and the coprocessor Xmem request/response channels.
//  Round-robin arbitrates address phases and tracks outstanding transactions in order.
//  Routes each rvalid back to its owner and buffers Xmem responses, because OBI rvalid cannot stall.
//  Sits between the core/coprocessor pair and the data memory.
// PARAMETERS
//  MAX_OUTSTANDING  2  max bus transactions in flight (ID FIFO depth, >=1)
//  XMEM_RESP_DEPTH  2  Xmem response buffer entries (>=1)
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   synchronous reset, active-high
//  core_req_i     in   1   core OBI request
//  core_gnt_o     out  1   core OBI grant
//  core_addr_i    in   32  core address
//  core_we_i      in   1   core write enable
//  core_be_i      in   4   core byte enables
//  core_wdata_i   in   32  core write data
//  core_rvalid_o  out  1   core response valid
//  core_rdata_o   out  32  core read data
//  xmem_valid_i   in   1   Xmem request valid
//  xmem_ready_o   out  1   Xmem request accepted
//  xmem_laddr_i   in   32  Xmem byte address
//  xmem_we_i      in   1   Xmem store (1) / load (0)
//  xmem_width_i   in   3   0=byte 1=half 2=word; other codes illegal
//  xmem_wdata_i   in   32  Xmem store data, LSB-aligned
//  xmem_rvalid_o  out  1   Xmem response valid
//  xmem_rready_i  in   1   Xmem response ready
//  xmem_rdata_o   out  32  Xmem load data, LSB-aligned, zero-extended
//  xmem_status_o  out  1   0=ok, 1=misaligned/illegal-width error
//  data_req_o     out  1   memory OBI request
//  data_gnt_i     in   1   memory OBI grant
//  data_addr_o    out  32  memory address (word-aligned for Xmem)
//  data_we_o      out  1   memory write enable
//  data_be_o      out  4   memory byte enables
//  data_wdata_o   out  32  memory write data
//  data_rvalid_i  in   1   memory response valid
//  data_rdata_i   in   32  memory read data
// BEHAVIOUR
//  Reset:
//   - Owner lock, round-robin pointer (favours core), ID FIFO and response buffer are cleared.
//   - While rst_i=1 these outputs are 0: data_req_o, core_gnt_o, xmem_ready_o, core_rvalid_o, xmem_rvalid_o.
//   - A response arriving after reset for a pre-reset request is dropped; memory is reset with the core.
//  Issue gating:
//   - data_req_o=0 while the ID FIFO is full. A pop in the same cycle does not free the slot.
//   - Xmem is eligible only if the bus-bound Xmem request is well-formed and
//     credits = XMEM_RESP_DEPTH - buf_count - xmem_inflight > 0.
//  Arbitration:
//   - Unlocked and both requesting: grant goes to the requester not served last.
//   - Pointer updates on each req&&gnt handshake.
//  Lock (OBI stability):
//   - If data_req_o=1 and data_gnt_i=0, the owner is registered and held until gnt.
//   - Address/data outputs are stable while locked.
//  Address phase:
//   - Combinational mux of the winner onto data_*.
//   - core_gnt_o = data_gnt_i & core selected; xmem_ready_o = data_gnt_i & Xmem selected.
//   - The core path adds zero cycles.
//  Xmem formatting:
//   - data_addr_o = {laddr[31:2],2'b00}.
//   - be: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111.
//   - data_wdata_o = wdata << 8*off.
//  Misaligned request:
//   - Triggers: half with off[0]=1, word with off!=0, or width code >=3.
//   - Never goes to the bus. Accepted (xmem_ready_o=1) only when xmem_inflight=0, the buffer is not full, and the core is not locked.
//   - The accept pushes an error entry {rdata=0,status=1}.
//  ID FIFO:
//   - On each bus handshake, pushes {owner, off[1:0]}.
//   - data_rvalid_i pops the head.
//  Response routing:
//   - Head=core: core_rvalid_o=1 and core_rdata_o=data_rdata_i in the same cycle.
//   - Head=Xmem: pushes {data_rdata_i>>8*off masked to width, status=0} into the response buffer.
//   - The response buffer is never full here, by credits.
//  Xmem response:
//   - xmem_rvalid_o = buffer non-empty; the entry pops on xmem_rvalid_o&&xmem_rready_i.
//   - Latency is 1 cycle after data_rvalid_i.
//   - Buffer push and pop in the same cycle are allowed at any occupancy.
//  Error cases:
//   - data_rvalid_i with an empty ID FIFO is ignored and flagged by an assertion.
//   - Responses are strictly in order per owner and globally.
// STRUCTURE
//  - Additions to cv32e40p_x_if_pkg:
//    - xmem_width_e (BYTE=0, HALF=1, WORD=2)
//    - arb_owner_e (OWN_CORE, OWN_XMEM)
//    - XMEM_STATUS_OK/ERR constants
//    - struct arb_id_t {owner, off[1:0]}
//    - struct xmem_rsp_t {rdata[31:0], status}
//  - One sub-module, cv32e40p_xmem_arb_fifo: parameterised type/depth synchronous FIFO with
//    full/empty/count and same-cycle push+pop. Instantiated as the ID FIFO and the response buffer.
// TESTING
//  1 Core only, gnt same cycle:
//    core_req addr 0x100 load -> data_req_o=1 same cycle; core_gnt_o=1;
//    rvalid rdata 0xDEADBEEF -> core_rvalid_o=1, core_rdata_o=0xDEADBEEF same cycle.
//  2 Both requesting every cycle, gnt=1:
//    grants alternate core, Xmem, core, Xmem; pointer starts at core after reset.
//  3 Xmem half load, laddr 0x202, mem rdata 0xABCD1234:
//    -> data_addr_o=0x200, be=4'b1100;
//    xmem_rdata_o=0x0000ABCD one cycle after rvalid, status=0.
//  4 Xmem word store at 0x203:
//    -> no data_req_o; xmem_rvalid_o next cycle with status=1, rdata=0.
//  5 Xmem rready=0 with XMEM_RESP_DEPTH=2:
//    after 2 Xmem loads complete, third Xmem request is held (xmem_ready_o=0) while core requests still pass.
//  6 gnt=0 for 3 cycles with core owner, Xmem raising valid meanwhile:
//    -> data_* stable, owner unchanged.
//    Separately: rst_i asserted with 2 outstanding -> all outputs 0, later stray rvalid ignored.

Source files
------------

// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the core/coprocessor memory interface: Xmem width codes,
// arbiter ownership tags and the records carried by the arbiter FIFOs.
package cv32e40p_x_if_pkg;

  typedef enum logic [2:0] {
    XMEM_BYTE = 3'd0,
    XMEM_HALF = 3'd1,
    XMEM_WORD = 3'd2
  } xmem_width_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_XMEM = 1'b1
  } arb_owner_e;

  localparam logic XMEM_STATUS_OK  = 1'b0;
  localparam logic XMEM_STATUS_ERR = 1'b1;

  // The width travels with the offset so the load can be masked on return.
  typedef struct packed {
    arb_owner_e  owner;
    xmem_width_e width;
    logic [1:0]  off;
  } arb_id_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        status;
  } xmem_rsp_t;

  function automatic logic xmem_aligned(input xmem_width_e width, input logic [1:0] off);
    case (width)
      XMEM_BYTE: return 1'b1;
      XMEM_HALF: return !off[0];
      XMEM_WORD: return (off == 2'd0);
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] xmem_be(input xmem_width_e width, input logic [1:0] off);
    case (width)
      XMEM_BYTE: return 4'b0001 << off;
      XMEM_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] xmem_extract(input logic [31:0] rdata,
                                               input xmem_width_e width,
                                               input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (width)
      XMEM_BYTE: return shifted & 32'h0000_00ff;
      XMEM_HALF: return shifted & 32'h0000_ffff;
      XMEM_WORD: return shifted;
      default:   return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40p_xmem_arb_fifo.sv
// Small synchronous FIFO of an arbitrary packed type; push and pop may occur in
// the same cycle, and a push into a full FIFO succeeds when a pop frees the slot.
module cv32e40p_xmem_arb_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  T                 mem [DEPTH];
  ptr_t             wptr_q;
  ptr_t             rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is carried by count_q,
  // which keeps the array a plain register file without a reset tree.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= data_i;
  end

endmodule

// File: rtl/cv32e40p_xmem_data_arbiter.sv
// Shares the OBI data port between the core LSU and the coprocessor Xmem channel:
// round-robin address phase with OBI lock, in-order ID tracking, buffered Xmem responses.
module cv32e40p_xmem_data_arbiter
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned XMEM_RESP_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  input  logic        xmem_valid_i,
  output logic        xmem_ready_o,
  input  logic [31:0] xmem_laddr_i,
  input  logic        xmem_we_i,
  input  logic [2:0]  xmem_width_i,
  input  logic [31:0] xmem_wdata_i,
  output logic        xmem_rvalid_o,
  input  logic        xmem_rready_i,
  output logic [31:0] xmem_rdata_o,
  output logic        xmem_status_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int unsigned ID_CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BUF_CNT_W = $clog2(XMEM_RESP_DEPTH + 1);

  logic                 lock_q;
  arb_owner_e           lock_owner_q;
  arb_owner_e           rr_prio_q;
  logic [ID_CNT_W-1:0]  xmem_inflight_q;

  arb_owner_e           sel;
  logic                 sel_req;
  logic                 handshake;
  logic                 xmem_bus_gnt;
  logic                 xmem_credit;
  logic                 xmem_bus_req;
  logic                 xmem_misaligned;
  logic                 misaligned_accept;
  logic [1:0]           xmem_off;
  xmem_width_e          xmem_width;

  arb_id_t              id_push_data;
  arb_id_t              id_head;
  logic                 id_full;
  logic                 id_empty;
  logic [ID_CNT_W-1:0]  id_count;
  logic                 id_pop;
  logic                 head_is_xmem;

  xmem_rsp_t            buf_push_data;
  xmem_rsp_t            buf_head;
  logic                 buf_push;
  logic                 buf_pop;
  logic                 buf_full;
  logic                 buf_empty;
  logic [BUF_CNT_W-1:0] buf_count;

  assign xmem_off        = xmem_laddr_i[1:0];
  assign xmem_width      = xmem_width_e'(xmem_width_i);
  assign xmem_misaligned = xmem_valid_i && !xmem_aligned(xmem_width, xmem_off);

  // A bus-bound Xmem load must already own a response slot, since rvalid cannot stall.
  always_comb begin
    xmem_credit = (int'(XMEM_RESP_DEPTH) - int'(buf_count) - int'(xmem_inflight_q)) > 0;
  end
  assign xmem_bus_req = xmem_valid_i && !xmem_misaligned && xmem_credit;

  // NOTE: every signal gets a default at the top of an always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = OWN_CORE;
    if (lock_q)                          sel = lock_owner_q;
    else if (core_req_i && xmem_bus_req) sel = rr_prio_q;
    else if (xmem_bus_req)               sel = OWN_XMEM;
  end

  assign sel_req      = (sel == OWN_CORE) ? core_req_i : xmem_bus_req;
  assign data_req_o   = !rst_i && !id_full && sel_req;
  assign handshake    = data_req_o && data_gnt_i;
  assign core_gnt_o   = handshake && (sel == OWN_CORE);
  assign xmem_bus_gnt = handshake && (sel == OWN_XMEM);

  // Errored requests bypass the bus, so they wait until nothing Xmem is ahead of them.
  assign misaligned_accept = !rst_i && xmem_misaligned && (xmem_inflight_q == '0)
                             && !buf_full && !lock_q;
  assign xmem_ready_o      = xmem_bus_gnt || misaligned_accept;

  always_comb begin
    data_addr_o  = core_addr_i;
    data_we_o    = core_we_i;
    data_be_o    = core_be_i;
    data_wdata_o = core_wdata_i;
    if (sel == OWN_XMEM) begin
      data_addr_o  = {xmem_laddr_i[31:2], 2'b00};
      data_we_o    = xmem_we_i;
      data_be_o    = xmem_be(xmem_width, xmem_off);
      data_wdata_o = xmem_wdata_i << {xmem_off, 3'b000};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q          <= 1'b0;
      lock_owner_q    <= OWN_CORE;
      rr_prio_q       <= OWN_CORE;
      xmem_inflight_q <= '0;
    end else begin
      lock_q <= data_req_o && !data_gnt_i;
      if (data_req_o && !data_gnt_i) lock_owner_q <= sel;
      if (handshake) rr_prio_q <= (sel == OWN_CORE) ? OWN_XMEM : OWN_CORE;
      case ({xmem_bus_gnt, id_pop && head_is_xmem})
        2'b10:   xmem_inflight_q <= xmem_inflight_q + ID_CNT_W'(1);
        2'b01:   xmem_inflight_q <= xmem_inflight_q - ID_CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign id_push_data = '{owner: sel, width: xmem_width, off: xmem_off};

  cv32e40p_xmem_arb_fifo #(
    .T     (arb_id_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake),
    .data_i  (id_push_data),
    .pop_i   (id_pop),
    .data_o  (id_head),
    .full_o  (id_full),
    .empty_o (id_empty),
    .count_o (id_count)
  );

  assign id_pop        = data_rvalid_i && !id_empty;
  assign head_is_xmem  = (id_head.owner == OWN_XMEM);
  assign core_rvalid_o = !rst_i && id_pop && !head_is_xmem;
  assign core_rdata_o  = data_rdata_i;

  always_comb begin
    buf_push_data = '{rdata: xmem_extract(data_rdata_i, id_head.width, id_head.off),
                      status: XMEM_STATUS_OK};
    if (misaligned_accept) buf_push_data = '{rdata: 32'h0, status: XMEM_STATUS_ERR};
  end

  assign buf_push = !rst_i && ((id_pop && head_is_xmem) || misaligned_accept);
  assign buf_pop  = xmem_rvalid_o && xmem_rready_i;

  cv32e40p_xmem_arb_fifo #(
    .T     (xmem_rsp_t),
    .DEPTH (XMEM_RESP_DEPTH)
  ) u_rsp_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (buf_push),
    .data_i  (buf_push_data),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign xmem_rvalid_o = !rst_i && !buf_empty;
  assign xmem_rdata_o  = buf_head.rdata;
  assign xmem_status_o = buf_head.status;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (data_rvalid_i) begin
        assert (!id_empty)
          else $warning("stray data_rvalid_i with no outstanding transaction dropped");
      end
      assert (int'(id_count) <= int'(MAX_OUTSTANDING))
        else $error("id fifo occupancy out of range");
    end
  end

endmodule
